hood_mode_scheduler: RTL and testbench
======================================

# hood_mode_scheduler

Sequencing controller for the range-hood fan datapath. It arbitrates the four front-panel key pulses and generates the 1-second tick internally. It enforces the once-per-power-cycle hurricane (level 3) rule, runs the hurricane and return-to-idle countdowns, and accumulates fan runtime for the cleaning reminder. It sits between the debounced key decoder and the fan driver / display logic.

## Interface
Parameters:
- TICK_DIV, 100000000: clk cycles per 1-second tick; must be ≥ 2.
- HURRICANE_S, 60: hurricane duration in seconds; range 1..255.
- RETURN_S, 60: return-to-idle countdown in seconds; range 1..255.
- CLEAN_REMIND_S, 36000: runtime threshold in seconds that raises `remind`.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- menu_key  in  1  single-cycle pulse.
- level1_key  in  1  single-cycle pulse.
- level2_key  in  1  single-cycle pulse.
- level3_key  in  1  single-cycle pulse.
- clean_ack  in  1  single-cycle pulse; clears runtime and remind.
- state  out  3  0=IDLE, 1=LVL1, 2=LVL2, 3=LVL3, 4=RETURN.
- fan_level  out  2  fan drive level, 0..3.
- busy  out  1  high when fan_level ≠ 0.
- countdown  out  8  seconds remaining in LVL3/RETURN, otherwise 0.
- runtime  out  16  accumulated fan-on seconds; saturates at 65535.
- level3_used  out  1  high once hurricane has been entered since reset.
- remind  out  1  cleaning reminder.

## Operation
- Prescaler:
  - Counts 0..TICK_DIV-1 continuously, in every state.
  - `tick` is an internal 1-cycle pulse on the cycle the count equals TICK_DIV-1.
- Arbitration:
  - Only requests that are legal in the current state are considered.
  - Among legal requests, priority is menu > level3 > level2 > level1.
  - All other keys in the same cycle are dropped.
- IDLE:
  - level1 → LVL1.
  - level2 → LVL2.
  - level3 with level3_used=0 → LVL3; load countdown=HURRICANE_S; set level3_used.
  - level3 with level3_used=1 is not legal; a lower legal key may win instead.
- LVL1: menu → IDLE; level2 → LVL2; all other keys ignored.
- LVL2: menu → IDLE; level1 → LVL1; all other keys ignored.
- LVL3:
  - menu → RETURN; load countdown=RETURN_S.
  - Otherwise, on each tick: if countdown==1, go to LVL2 with countdown=0; else decrement countdown.
  - level1/2/3 keys ignored.
  - If a menu pulse and the final tick occur in the same cycle, menu wins.
- RETURN:
  - Fan is off.
  - On each tick: if countdown==1, go to IDLE with countdown=0; else decrement countdown.
  - All keys ignored.
- fan_level mapping: IDLE=0, LVL1=1, LVL2=2, LVL3=3, RETURN=0.
- runtime:
  - On a tick with fan_level≠0 (evaluated on the registered state), increment by 1, saturating at 65535.
  - clean_ack clears runtime to 0; if a tick occurs in the same cycle, the clear wins.
- level3_used is cleared only by rst.

## Timing
- All outputs are registered.
- A key pulse in cycle N is reflected on state, fan_level, busy and countdown in cycle N+1.
- remind is registered from runtime and asserts one cycle after runtime reaches CLEAN_REMIND_S.
- Countdown length: LVL3 lasts exactly HURRICANE_S ticks after entry; RETURN lasts exactly RETURN_S ticks.
- The first tick after entry may occur at any phase; the prescaler is not restarted on state change.
- Reset values:
  - state=IDLE, fan_level=0, busy=0, countdown=0.
  - runtime=0, level3_used=0, remind=0, prescaler=0.
- rst asserted mid-LVL3 or mid-RETURN forces all reset values on the next edge. No countdown state survives reset.

## Configuration
- `HOOD_REMIND_EN` defined:
  - remind = (runtime ≥ CLEAN_REMIND_S), registered.
  - clean_ack clears runtime and remind.
- `HOOD_REMIND_EN` undefined:
  - remind is tied to 0 and clean_ack is ignored.
  - runtime still accumulates and saturates as specified.

## Test plan
All scenarios use TICK_DIV=4, HURRICANE_S=5, RETURN_S=3, CLEAN_REMIND_S=6, with `HOOD_REMIND_EN` defined.
- Reset: hold rst 3 cycles → state=0, fan_level=0, busy=0, countdown=0, runtime=0, level3_used=0, remind=0.
- Hurricane:
  - level3_key in IDLE → next cycle state=3, fan_level=3, countdown=5, level3_used=1.
  - After 5 ticks → state=2, countdown=0.
  - menu → IDLE; then level3_key alone → state stays 0.
- Early exit:
  - Enter LVL3; after 2 ticks (countdown=3) pulse menu → state=4, fan_level=0, busy=0, countdown=3.
  - After 3 ticks → state=0.
  - Keys during RETURN have no effect.
- Arbitration:
  - IDLE, level1+level2 same cycle → state=2.
  - IDLE with level3_used=1, level3+level1 same cycle → state=1.
  - LVL2, menu+level1 same cycle → state=0.
- Runtime and reminder:
  - Hold LVL1 for 6 ticks → runtime=6, remind=1 one cycle later.
  - clean_ack coincident with a tick → runtime=0, remind=0.
- Reset mid-operation: rst during RETURN with countdown=2 → all reset values next cycle, including level3_used=0; level3_key then enters LVL3 again.

Source files
------------

// File: rtl/hood_mode_scheduler.sv
// Range-hood mode sequencer: key arbitration, hurricane/return countdowns and runtime tracking.
// Optional cleaning reminder and clean_ack clearing are enabled by defining HOOD_REMIND_EN.
module hood_mode_scheduler #(
  parameter int TICK_DIV       = 100000000,
  parameter int HURRICANE_S    = 60,
  parameter int RETURN_S       = 60,
  parameter int CLEAN_REMIND_S = 36000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        menu_key,
  input  logic        level1_key,
  input  logic        level2_key,
  input  logic        level3_key,
  input  logic        clean_ack,
  output logic [2:0]  state,
  output logic [1:0]  fan_level,
  output logic        busy,
  output logic [7:0]  countdown,
  output logic [15:0] runtime,
  output logic        level3_used,
  output logic        remind
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LVL1   = 3'd1,
    S_LVL2   = 3'd2,
    S_LVL3   = 3'd3,
    S_RETURN = 3'd4
  } mode_e;

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    HURR_CD   = 8'(HURRICANE_S);
  localparam logic [7:0]    RET_CD    = 8'(RETURN_S);

  mode_e         state_q, state_d;
  logic [7:0]    countdown_q, countdown_d;
  logic          level3Used_q, level3Used_d;
  logic [1:0]    fanLevel_q, fanLevel_d;
  logic          busy_q, busy_d;
  logic [15:0]   runtime_q, runtime_d;
  logic          remind_q, remind_d;
  logic [PW-1:0] prescale_q;
  logic          tick;

  assign tick = (prescale_q == TICK_LAST);

  // Free-running prescaler; never restarted by mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (tick) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      countdown_q  <= '0;
      level3Used_q <= 1'b0;
      fanLevel_q   <= '0;
      busy_q       <= 1'b0;
      runtime_q    <= '0;
      remind_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      countdown_q  <= countdown_d;
      level3Used_q <= level3Used_d;
      fanLevel_q   <= fanLevel_d;
      busy_q       <= busy_d;
      runtime_q    <= runtime_d;
      remind_q     <= remind_d;
    end
  end

  // Each state tests only its legal keys, highest priority first, so illegal keys never block lower ones.
  always_comb begin
    state_d      = state_q;
    countdown_d  = countdown_q;
    level3Used_d = level3Used_q;
    case (state_q)
      S_IDLE: begin
        if (level3_key && !level3Used_q) begin
          state_d      = S_LVL3;
          countdown_d  = HURR_CD;
          level3Used_d = 1'b1;
        end else if (level2_key) begin
          state_d = S_LVL2;
        end else if (level1_key) begin
          state_d = S_LVL1;
        end
      end
      S_LVL1: begin
        if (menu_key)        state_d = S_IDLE;
        else if (level2_key) state_d = S_LVL2;
      end
      S_LVL2: begin
        if (menu_key)        state_d = S_IDLE;
        else if (level1_key) state_d = S_LVL1;
      end
      S_LVL3: begin
        if (menu_key) begin
          state_d     = S_RETURN;
          countdown_d = RET_CD;
        end else if (tick) begin
          if (countdown_q == 8'd1) begin
            state_d     = S_LVL2;
            countdown_d = 8'd0;
          end else begin
            countdown_d = countdown_q - 8'd1;
          end
        end
      end
      S_RETURN: begin
        if (tick) begin
          if (countdown_q == 8'd1) begin
            state_d     = S_IDLE;
            countdown_d = 8'd0;
          end else begin
            countdown_d = countdown_q - 8'd1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        countdown_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    fanLevel_d = 2'd0;
    case (state_d)
      S_LVL1:  fanLevel_d = 2'd1;
      S_LVL2:  fanLevel_d = 2'd2;
      S_LVL3:  fanLevel_d = 2'd3;
      default: fanLevel_d = 2'd0;
    endcase
    busy_d = (fanLevel_d != 2'd0);
  end

`ifdef HOOD_REMIND_EN
  localparam logic [31:0] REMIND_TH = 32'(CLEAN_REMIND_S);
`else
  logic unusedCfg;
  assign unusedCfg = clean_ack ^ (CLEAN_REMIND_S != 0);
`endif

  // Runtime counts seconds the fan was on during the previous cycle; a clean_ack clear beats a tick.
  always_comb begin
    runtime_d = runtime_q;
    if (tick && (fanLevel_q != 2'd0) && (runtime_q != 16'hFFFF)) begin
      runtime_d = runtime_q + 16'd1;
    end
`ifdef HOOD_REMIND_EN
    if (clean_ack) begin
      runtime_d = 16'd0;
    end
    remind_d = clean_ack ? 1'b0 : ({16'd0, runtime_q} >= REMIND_TH);
`else
    remind_d = 1'b0;
`endif
  end

  assign state       = state_q;
  assign fan_level   = fanLevel_q;
  assign busy        = busy_q;
  assign countdown   = countdown_q;
  assign runtime     = runtime_q;
  assign level3_used = level3Used_q;
  assign remind      = remind_q;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Bench for hood_mode_scheduler: directed scenarios with literal expectations, then random keys,
// with every cycle compared against a behavioural model of the mode rules.
module tb_hood_mode_scheduler;

  localparam int TICK_DIV       = 4;
  localparam int HURRICANE_S    = 5;
  localparam int RETURN_S       = 3;
  localparam int CLEAN_REMIND_S = 6;
`ifdef HOOD_REMIND_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        menuKey = 1'b0, l1Key = 1'b0, l2Key = 1'b0, l3Key = 1'b0, cleanAck = 1'b0;
  logic [2:0]  dState;
  logic [1:0]  dFan;
  logic        dBusy;
  logic [7:0]  dCd;
  logic [15:0] dRuntime;
  logic        dUsed;
  logic        dRemind;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0..4, seconds left, runtime seconds, reminder and hurricane-used flag.
  int mMode = 0, mCd = 0, mRt = 0, mCycle = 0;
  bit mUsed = 1'b0, mRem = 1'b0;

  hood_mode_scheduler #(
    .TICK_DIV(TICK_DIV), .HURRICANE_S(HURRICANE_S),
    .RETURN_S(RETURN_S), .CLEAN_REMIND_S(CLEAN_REMIND_S)
  ) dut (
    .clk(clk), .rst(rst),
    .menu_key(menuKey), .level1_key(l1Key), .level2_key(l2Key), .level3_key(l3Key),
    .clean_ack(cleanAck),
    .state(dState), .fan_level(dFan), .busy(dBusy), .countdown(dCd),
    .runtime(dRuntime), .level3_used(dUsed), .remind(dRemind)
  );

  always #5 clk = ~clk;

  function automatic int fanOf(input int mode);
    return (mode >= 1 && mode <= 3) ? mode : 0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock, given the inputs sampled at that edge.
  task automatic modelStep(input bit r, input bit m, input bit k1, input bit k2, input bit k3, input bit ack);
    bit tick;
    bit newRem;
    tick = ((mCycle % TICK_DIV) == TICK_DIV - 1);
    if (r) begin
      mMode = 0; mCd = 0; mRt = 0; mUsed = 0; mRem = 0; mCycle = 0;
      return;
    end
    newRem = REM_EN && !ack && (mRt >= CLEAN_REMIND_S);
    if (REM_EN && ack)                   mRt = 0;
    else if (tick && fanOf(mMode) != 0)  mRt = (mRt < 65535) ? mRt + 1 : mRt;
    mRem = newRem;
    case (mMode)
      0: begin
        if (k3 && !mUsed) begin mMode = 3; mCd = HURRICANE_S; mUsed = 1; end
        else if (k2) mMode = 2;
        else if (k1) mMode = 1;
      end
      1: if (m) mMode = 0; else if (k2) mMode = 2;
      2: if (m) mMode = 0; else if (k1) mMode = 1;
      3: begin
        if (m) begin mMode = 4; mCd = RETURN_S; end
        else if (tick) begin
          mCd = mCd - 1;
          if (mCd == 0) mMode = 2;
        end
      end
      default: begin
        if (tick) begin
          mCd = mCd - 1;
          if (mCd == 0) mMode = 0;
        end
      end
    endcase
    mCycle++;
  endtask

  task automatic checkOutput();
    cmp("state", dState, mMode);
    cmp("fan_level", dFan, fanOf(mMode));
    cmp("busy", dBusy, fanOf(mMode) != 0);
    cmp("countdown", dCd, mCd);
    cmp("runtime", dRuntime, mRt);
    cmp("level3_used", dUsed, mUsed);
    cmp("remind", dRemind, mRem);
  endtask

  // Drive one cycle of inputs away from the active edge, then check just after it.
  task automatic applyStimulus(input bit r, input bit m, input bit k1, input bit k2, input bit k3, input bit ack);
    @(negedge clk);
    rst = r; menuKey = m; l1Key = k1; l2Key = k2; l3Key = k3; cleanAck = ack;
    modelStep(r, m, k1, k2, k3, ack);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkAllReset(input string tag);
    cmp({tag, " state"}, dState, 0);
    cmp({tag, " fan_level"}, dFan, 0);
    cmp({tag, " busy"}, dBusy, 0);
    cmp({tag, " countdown"}, dCd, 0);
    cmp({tag, " runtime"}, dRuntime, 0);
    cmp({tag, " level3_used"}, dUsed, 0);
    cmp({tag, " remind"}, dRemind, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    checkAllReset("reset");

    // Hurricane entry, natural expiry into LVL2, then level3 no longer legal.
    applyStimulus(0, 0, 0, 0, 1, 0);
    cmp("hurr state", dState, 3);
    cmp("hurr fan", dFan, 3);
    cmp("hurr cd", dCd, 5);
    cmp("hurr used", dUsed, 1);
    for (int i = 0; i < 40 && dState != 3'd2; i++) idle();
    cmp("hurr expire state", dState, 2);
    cmp("hurr expire cd", dCd, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    cmp("menu to idle", dState, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    cmp("level3 reused", dState, 0);

    // Arbitration.
    applyStimulus(0, 0, 1, 0, 1, 0);
    cmp("arb l3used+l1", dState, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    cmp("arb l1+l2", dState, 2);
    applyStimulus(0, 1, 1, 0, 0, 0);
    cmp("arb menu+l1", dState, 0);

    // Runtime and reminder from a clean reset.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40 && dRuntime != 16'd6; i++) idle();
    cmp("runtime six", dRuntime, 6);
    cmp("remind not yet", dRemind, 0);
    idle();
    cmp("remind asserted", dRemind, REM_EN ? 1 : 0);
    for (int i = 0; i < 4 && (mCycle % TICK_DIV) != TICK_DIV - 1; i++) idle();
    applyStimulus(0, 0, 0, 0, 0, 1);
`ifdef HOOD_REMIND_EN
    cmp("ack runtime", dRuntime, 0);
    cmp("ack remind", dRemind, 0);
`endif

    // Early exit from hurricane through RETURN; keys ignored meanwhile.
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20 && dCd != 8'd3; i++) idle();
    applyStimulus(0, 1, 0, 0, 0, 0);
    cmp("early state", dState, 4);
    cmp("early fan", dFan, 0);
    cmp("early busy", dBusy, 0);
    cmp("early cd", dCd, 3);
    applyStimulus(0, 0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    cmp("return keys ignored", dState, 4);
    for (int i = 0; i < 20 && dState != 3'd0; i++) idle();
    cmp("return done", dState, 0);

    // Reset mid-RETURN.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && dCd != 8'd2; i++) idle();
    cmp("pre-reset cd", dCd, 2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkAllReset("midreset");
    applyStimulus(0, 0, 0, 0, 1, 0);
    cmp("reenter hurr", dState, 3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
